// File: rtl/uart_frame_packer.sv
// uart_frame_packer
//   Packs the UART RX byte stream into fixed FRAME_BYTES frames for the
//   coprocessor. The block is double-buffered. One frame assembles while the
//   previously completed frame is held for the consumer. If the line goes idle
//   in the middle of a frame, the partial frame is discarded after TIMEOUT_CYC
//   cycles so the host can resynchronise.
//
// Ports
//   clk, rst         system clock; synchronous active-high reset
//   rx_byte[7:0]     received byte, qualified by rx_byte_valid (1-cycle strobe)
//   frame            held frame, byte k at [8k+7:8k], byte 0 = first received
//   frame_valid      hold register has an unconsumed frame
//   frame_ready      consumer accepts when frame_valid & frame_ready
//   fill_level[7:0]  bytes currently in the assembly buffer
//   overrun          pulse: completed frame dropped because hold was busy
//   timeout          pulse: partial frame discarded after idle timeout
//   frame_count      frames handed to the consumer (wraps)
//   drop_count       overruns + timeouts (saturates)
module uart_frame_packer #(
  parameter int FRAME_BYTES = 16,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_byte_valid,
  output logic [FRAME_BYTES*8-1:0] frame,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [7:0]               fill_level,
  output logic                     overrun,
  output logic                     timeout,
  output logic [CNT_W-1:0]         frame_count,
  output logic [CNT_W-1:0]         drop_count
);

  localparam logic [7:0]  LAST_SLOT = 8'(FRAME_BYTES - 1);
  localparam logic [31:0] TMO_LAST  = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);
  localparam bit          TMO_EN    = (TIMEOUT_CYC != 0);

  typedef enum logic {EMPTY, FULL} hold_state_t;

  hold_state_t                  state, state_nxt;
  logic [FRAME_BYTES-1:0][7:0]  asm_buf;
  logic                         cmpl_pend;  // completed frame waiting to move to hold
  logic [31:0]                  idle_cnt;
  logic                         accept, load, drop_ovr, tmo_hit, last_byte;

  assign frame_valid = (state == FULL);
  assign accept      = frame_valid & frame_ready;
  assign last_byte   = rx_byte_valid & (fill_level == LAST_SLOT);

  // A strobe on the expiry cycle takes priority, so expiry needs an idle cycle.
  assign tmo_hit = TMO_EN && (fill_level != 8'd0) && !rx_byte_valid &&
                   (idle_cnt == TMO_LAST);

  // Assembly slots. Each slot only looks at its own index, so no wide mux
  // is needed on the write path.
  for (genvar k = 0; k < FRAME_BYTES; k++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rx_byte_valid && fill_level == 8'(k)) asm_buf[k] <= rx_byte;
    end
  end

  // Hold FSM. A completion that meets a same-cycle accept reloads the hold
  // register and stays FULL instead of overrunning.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop_ovr  = 1'b0;
    if (cmpl_pend) begin
      if (state == EMPTY || accept) begin
        load      = 1'b1;
        state_nxt = FULL;
      end else begin
        drop_ovr  = 1'b1;
      end
    end else if (accept) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      frame       <= '0;
      fill_level  <= 8'd0;
      cmpl_pend   <= 1'b0;
      idle_cnt    <= 32'd0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      state     <= state_nxt;
      overrun   <= drop_ovr;
      timeout   <= tmo_hit;
      cmpl_pend <= last_byte;

      // asm_buf already holds the final byte by the edge after completion.
      if (load) frame <= asm_buf;

      if (rx_byte_valid) begin
        fill_level <= last_byte ? 8'd0 : fill_level + 8'd1;
        idle_cnt   <= 32'd0;
      end else if (tmo_hit) begin
        fill_level <= 8'd0;
        idle_cnt   <= 32'd0;
      end else if (TMO_EN && fill_level != 8'd0) begin
        idle_cnt   <= idle_cnt + 32'd1;
      end else begin
        idle_cnt   <= 32'd0;
      end

      if (accept) frame_count <= frame_count + 1'b1;
      if ((drop_ovr || tmo_hit) && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
module tb_uart_frame_packer;
  localparam int FB  = 16;
  localparam int TMO = 100;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      rx_byte;
  logic            rx_byte_valid;
  logic [FB*8-1:0] frame;
  logic            frame_valid;
  logic            frame_ready;
  logic [7:0]      fill_level;
  logic            overrun;
  logic            timeout;
  logic [CW-1:0]   frame_count;
  logic [CW-1:0]   drop_count;

  int              checks = 0;
  int              errors = 0;
  logic [127:0]    exp_q[$];
  logic [CW-1:0]   exp_fc;
  logic [CW-1:0]   exp_dc;

  always #5 clk = ~clk;

  uart_frame_packer #(.FRAME_BYTES(FB), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .frame(frame), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .fill_level(fill_level), .overrun(overrun), .timeout(timeout),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One strobe per call; consecutive calls give back-to-back bytes.
  task automatic send_byte(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input bit expect_out);
    logic [127:0] f;
    for (int k = 0; k < FB; k++) f[8*k +: 8] = base + 8'(k);
    if (expect_out) exp_q.push_back(f);
    for (int k = 0; k < FB; k++) send_byte(base + 8'(k));
  endtask

  task automatic bump_drop();
    if (exp_dc != '1) exp_dc++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) step();
    chk(tag, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    rst = 1'b1; rx_byte = 8'h00; rx_byte_valid = 1'b0; frame_ready = 1'b0;
    exp_fc = '0; exp_dc = '0;

    // Scoreboard consumer: every held cycle must show the queue head; pop on accept.
    fork
      forever begin
        @(negedge clk);
        if (!rst && frame_valid) begin
          if (exp_q.size() == 0) chk("unexpected_frame", 128'(frame_valid), 128'd0);
          else begin
            chk("frame_data", frame, exp_q[0]);
            if (frame_ready) begin
              void'(exp_q.pop_front());
              exp_fc++;
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk); #1;
    chk("rst_valid", 128'(frame_valid), 128'd0);
    chk("rst_fill",  128'(fill_level), 128'd0);
    chk("rst_frame", frame, 128'd0);
    chk("rst_fc",    128'(frame_count), 128'd0);
    chk("rst_dc",    128'(drop_count), 128'd0);
    chk("rst_pulse", 128'({overrun, timeout}), 128'd0);
    rst = 1'b0;

    // 1: single frame, latency 1 after final strobe
    frame_ready = 1'b1;
    exp_q.push_back(128'h0F0E0D0C0B0A09080706050403020100);
    for (int k = 0; k < FB; k++) send_byte(8'(k));
    chk("t1_not_yet", 128'(frame_valid), 128'd0);
    chk("t1_fill0",   128'(fill_level), 128'd0);
    step();
    chk("t1_valid",   128'(frame_valid), 128'd1);
    wait_drain("t1_drain");
    chk("t1_fc", 128'(frame_count), 128'(exp_fc));

    // 2: hold busy, second completion overruns
    frame_ready = 1'b0;
    send_frame(8'h20, 1'b1);
    send_frame(8'h40, 1'b0);
    chk("t2_no_ovr_yet", 128'(overrun), 128'd0);
    step();
    bump_drop();
    chk("t2_ovr",   128'(overrun), 128'd1);
    chk("t2_dc",    128'(drop_count), 128'(exp_dc));
    chk("t2_valid", 128'(frame_valid), 128'd1);
    step();
    chk("t2_ovr_pulse", 128'(overrun), 128'd0);

    // 3: accept on the transfer cycle of the next completion
    send_frame(8'h60, 1'b1);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk("t3_no_ovr", 128'(overrun), 128'd0);
    chk("t3_valid",  128'(frame_valid), 128'd1);
    chk("t3_dc",     128'(drop_count), 128'(exp_dc));
    step();
    frame_ready = 1'b1;
    wait_drain("t3_drain");
    chk("t3_fc", 128'(frame_count), 128'(exp_fc));

    // 4: timeout after 5 bytes, expiry on the 100th idle edge
    for (int k = 0; k < 5; k++) send_byte(8'hE0 + 8'(k));
    repeat (TMO - 1) step();
    chk("t4_pre_tmo",  128'(timeout), 128'd0);
    chk("t4_pre_fill", 128'(fill_level), 128'd5);
    step();
    bump_drop();
    chk("t4_tmo",  128'(timeout), 128'd1);
    chk("t4_fill", 128'(fill_level), 128'd0);
    chk("t4_dc",   128'(drop_count), 128'(exp_dc));
    step();
    chk("t4_tmo_pulse", 128'(timeout), 128'd0);
    send_frame(8'h80, 1'b1);
    wait_drain("t4_drain");

    // 5: strobe exactly on the expiry cycle wins
    for (int k = 0; k < 3; k++) send_byte(8'hA0 + 8'(k));
    repeat (TMO - 1) step();
    send_byte(8'hA3);
    chk("t5_no_tmo", 128'(timeout), 128'd0);
    chk("t5_fill",   128'(fill_level), 128'd4);
    chk("t5_dc",     128'(drop_count), 128'(exp_dc));
    begin
      logic [127:0] f;
      for (int k = 0; k < FB; k++) f[8*k +: 8] = 8'hA0 + 8'(k);
      exp_q.push_back(f);
      for (int k = 4; k < FB; k++) send_byte(8'hA0 + 8'(k));
    end
    wait_drain("t5_drain");

    // frame_count wraps
    for (int i = 0; i < 11; i++) send_frame(8'(i * 7), 1'b1);
    wait_drain("wrap_drain");
    chk("fc_wrap", 128'(frame_count), 128'(exp_fc));
    chk("fc_wrap_zero", 128'(frame_count), 128'd0);

    // drop_count saturates
    for (int i = 0; i < 14; i++) begin
      send_byte(8'h55);
      repeat (TMO) step();
      bump_drop();
    end
    chk("dc_sat", 128'(drop_count), 128'(exp_dc));
    chk("dc_all_ones", 128'(drop_count), 128'hF);

    // 6: reset mid-frame with a frame held
    frame_ready = 1'b0;
    send_frame(8'hC0, 1'b1);
    for (int k = 0; k < 9; k++) send_byte(8'(k));
    chk("t6_held", 128'(frame_valid), 128'd1);
    chk("t6_fill", 128'(fill_level), 128'd9);
    rst = 1'b1;
    step();
    exp_q.delete(); exp_fc = '0; exp_dc = '0;
    chk("t6_valid", 128'(frame_valid), 128'd0);
    chk("t6_fill0", 128'(fill_level), 128'd0);
    chk("t6_fc",    128'(frame_count), 128'd0);
    chk("t6_dc",    128'(drop_count), 128'd0);
    chk("t6_pulse", 128'({overrun, timeout}), 128'd0);
    rst = 1'b0;
    frame_ready = 1'b1;
    send_frame(8'h10, 1'b1);
    wait_drain("t6_drain");
    chk("t6_fc_after", 128'(frame_count), 128'(exp_fc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
